// File: rtl/multi_tree_gather.sv
// multi_tree_gather: packs a valid/ready sample stream into NUM-lane
// vectors for the multiplier tree, padding tlast-short groups with unity.
// Ports: clk, rst_n (async, active-low)
//   s_tdata/s_tvalid/s_tlast -> sample in, s_tready <- accept
//   din/din_tvalid -> one-cycle vector pulse to the tree
//   frame_cnt/pad_cnt -> emitted / padded vector counters (wrap)
module multi_tree_gather #(
  parameter int NUM = 8,
  parameter int DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] ONE_VALUE = DATA_WIDTH'(16'h0010),
  parameter int MIN_GAP = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     s_tdata,
  input  logic                      s_tvalid,
  input  logic                      s_tlast,
  output logic                      s_tready,
  output logic [NUM*DATA_WIDTH-1:0] din,
  output logic [NUM-1:0]            din_tvalid,
  output logic [15:0]               frame_cnt,
  output logic [15:0]               pad_cnt
);

  localparam int IW = $clog2(NUM);
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
  localparam bit NO_GAP = (MIN_GAP == 0);

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    GAP
  } state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             idx_q;
  logic [GW-1:0]             gap_q, gap_d;
  logic [DATA_WIDTH-1:0]     buf_q [NUM];
  logic [NUM*DATA_WIDTH-1:0] din_q, din_d;
  logic                      vld_q;
  logic [15:0]               frame_q;
  logic [15:0]               pad_q;

  logic accept;
  logic last_lane;
  logic done;
  logic short_grp;

  // Ready is decoded from state only, so it never depends on s_tvalid.
  assign s_tready = (state_q == FILL) ||
                    (NO_GAP && (state_q == EMIT));

  assign accept    = s_tvalid && s_tready;
  assign last_lane = (idx_q == LAST_IDX);
  assign done      = accept && (last_lane || s_tlast);
  assign short_grp = !last_lane;

  // Completing sample bypasses the buffer straight into its lane.
  always_comb begin
    din_d = din_q;
    if (done) begin
      for (int k = 0; k < NUM; k++) begin
        if (k < int'(idx_q))
          din_d[k*DATA_WIDTH +: DATA_WIDTH] = buf_q[k];
        else if (k == int'(idx_q))
          din_d[k*DATA_WIDTH +: DATA_WIDTH] = s_tdata;
        else
          din_d[k*DATA_WIDTH +: DATA_WIDTH] = ONE_VALUE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      FILL: begin
        if (done) state_d = EMIT;
      end
      EMIT: begin
        if (NO_GAP) begin
          state_d = done ? EMIT : FILL;
        end else begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = FILL;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      gap_q   <= '0;
      idx_q   <= '0;
      din_q   <= '0;
      vld_q   <= 1'b0;
      frame_q <= '0;
      pad_q   <= '0;
      for (int k = 0; k < NUM; k++) buf_q[k] <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      din_q   <= din_d;
      vld_q   <= done;
      if (accept) begin
        buf_q[idx_q] <= s_tdata;
        idx_q <= done ? '0 : idx_q + 1'b1;
      end
      if (done) frame_q <= frame_q + 16'd1;
      if (done && short_grp) pad_q <= pad_q + 16'd1;
    end
  end

  assign din        = din_q;
  assign din_tvalid = {NUM{vld_q}};
  assign frame_cnt  = frame_q;
  assign pad_cnt    = pad_q;

endmodule
